// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT queue with fill level,
// level interrupt and a sticky back-pressure flag.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clr_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   stall,
  output logic                   irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  // Extra pointer MSB makes the modular difference span 0..DEPTH.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == PW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign irq       = (count >= PW'(IRQ_LEVEL));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Set beats clear; flush leaves the flag alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall <= 1'b0;
    else     stall <= (in_valid & full) | (stall & ~clr_stall);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model.
// Directed scenarios plus a randomized run.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] in_data = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 0;
  logic       flush = 0;
  logic       clr_stall = 0;
  logic [4:0] count;
  logic       empty, full, stall, irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_stall = 0;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .clr_stall(clr_stall),
    .count(count), .empty(empty), .full(full),
    .stall(stall), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit mfull;
    bit pu;
    bit po;
    mfull = (q.size() == DEPTH);
    pu = in_valid && !mfull;
    po = out_ready && (q.size() != 0);
    m_stall = (in_valid && mfull) || (m_stall && !clr_stall);
    if (flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0; clr_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    q.delete();
    m_stall = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_and_stall();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = 8'(i); tick();
    end
    in_data = 8'h55; tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 0 || empty !== 1 || full !== 0 || in_ready !== 1 ||
        out_valid !== 0 || out_data !== 0 || stall !== 0 || irq !== 0) begin
      errors++;
      $display("FAIL reset: cnt=%0d e=%b f=%b rdy=%b v=%b d=%h st=%b irq=%b want 0 1 0 1 0 00 0 0",
               count, empty, full, in_ready, out_valid, out_data, stall, irq);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1; in_data = 8'hA5; tick();
    idle();
    checks++;
    if (out_valid !== 1 || out_data !== 8'hA5 || count !== 1 || irq !== 1) begin
      errors++;
      $display("FAIL single: v=%b d=%h cnt=%0d irq=%b want 1 a5 1 1",
               out_valid, out_data, count, irq);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = 8'(i); tick();
      checks++;
      if (count !== 5'(i + 1)) begin
        errors++;
        $display("FAIL fill_count: got %0d want %0d", count, i + 1);
      end
    end
    checks++;
    if (full !== 1 || in_ready !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL full: f=%b rdy=%b st=%b want 1 0 0", full, in_ready, stall);
    end
    in_data = 8'h55; tick();
    checks++;
    if (stall !== 1 || count !== 16) begin
      errors++;
      $display("FAIL stall_set: st=%b cnt=%0d want 1 16", stall, count);
    end
    clr_stall = 1; tick();
    checks++;
    if (stall !== 1) begin
      errors++;
      $display("FAIL stall_set_wins: got %b want 1", stall);
    end
    in_valid = 0; tick();
    clr_stall = 0;
    checks++;
    if (stall !== 0) begin
      errors++;
      $display("FAIL stall_clear: got %b want 0", stall);
    end
  endtask

  task automatic test_full_pop();
    in_valid = 1; in_data = 8'hC3; out_ready = 1;
    checks++;
    if (out_data !== 8'h00 || count !== 16) begin
      errors++;
      $display("FAIL full_pop_pre: d=%h cnt=%0d want 00 16", out_data, count);
    end
    tick();
    checks++;
    if (count !== 15 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL full_pop_c1: cnt=%0d d=%h want 15 01", count, out_data);
    end
    tick();
    in_valid = 0;
    checks++;
    if (count !== 15) begin
      errors++;
      $display("FAIL full_pop_c2: cnt=%0d want 15", count);
    end
    for (int i = 0; i < 15; i++) begin
      logic [7:0] exp;
      exp = (i < 14) ? 8'(i + 2) : 8'hC3;
      checks++;
      if (out_valid !== 1 || out_data !== exp) begin
        errors++;
        $display("FAIL drain[%0d]: v=%b d=%h want 1 %h", i, out_valid, out_data, exp);
      end
      tick();
    end
    idle();
    checks++;
    if (empty !== 1 || out_valid !== 0) begin
      errors++;
      $display("FAIL drain_empty: e=%b v=%b want 1 0", empty, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'($urandom); tick();
    end
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'($urandom);
      checks++;
      if (count !== 3 || out_data !== q[0]) begin
        errors++;
        $display("FAIL stream[%0d]: cnt=%0d d=%h want 3 %h", i, count, out_data, q[0]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    fill_and_stall();
    out_ready = 1;
    for (int i = 0; i < 11; i++) tick();
    idle();
    flush = 1; in_valid = 1; in_data = 8'h77;
    checks++;
    if (count !== 5 || stall !== 1 || in_ready !== 1) begin
      errors++;
      $display("FAIL flush_pre: cnt=%0d st=%b rdy=%b want 5 1 1", count, stall, in_ready);
    end
    tick();
    idle();
    checks++;
    if (count !== 0 || empty !== 1 || out_valid !== 0 || stall !== 1) begin
      errors++;
      $display("FAIL flush: cnt=%0d e=%b v=%b st=%b want 0 1 0 1",
               count, empty, out_valid, stall);
    end
    tick();
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL flush_drop: cnt=%0d want 0", count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill_and_stall();
    out_ready = 1;
    for (int i = 0; i < 9; i++) tick();
    idle();
    checks++;
    if (count !== 7 || stall !== 1) begin
      errors++;
      $display("FAIL areset_pre: cnt=%0d st=%b want 7 1", count, stall);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (count !== 0 || empty !== 1 || stall !== 0 || irq !== 0 ||
        in_ready !== 1 || out_valid !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL areset: cnt=%0d e=%b st=%b irq=%b rdy=%b v=%b d=%h want 0 1 0 0 1 0 00",
               count, empty, stall, irq, in_ready, out_valid, out_data);
    end
    q.delete();
    m_stall = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      flush     = ($urandom_range(0, 99) < 3);
      clr_stall = ($urandom_range(0, 99) < 10);
      in_data   = 8'($urandom);
      tick();
      checks++;
      if (count !== 5'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) || in_ready !== (q.size() != DEPTH) ||
          out_valid !== (q.size() != 0) || stall !== m_stall ||
          irq !== (q.size() >= 1) || (q.size() != 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL random[%0d]: cnt=%0d st=%b d=%h want cnt=%0d st=%b d=%h",
                 i, count, stall, out_data, q.size(), m_stall,
                 (q.size() != 0) ? q[0] : 8'h00);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
